// File: rtl/ssd_pkg.sv
// Shared types and sizing for the seven-segment display path.
package ssd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ssd_state_t;

  localparam int SSD_BIN_W  = 13;
  localparam int SSD_DIGITS = 4;

  // 10^n as a 64-bit constant, used to prove DIGITS can hold every BIN_W value.
  function automatic logic [63:0] ssd_pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets 3 added before the shift.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] digit_adj
);

  assign digit_adj = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/ssd_bin2bcd_seq.sv
// Iterative binary-to-BCD converter; bcd_out only ever holds a finished result.
module ssd_bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int BIN_W  = SSD_BIN_W,
  parameter int DIGITS = SSD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  start,
  input  logic                  auto_en,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int SW    = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  if (ssd_pow10(DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_digits_too_few
    $error("ssd_bin2bcd_seq: DIGITS too small for BIN_W");
  end

  ssd_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [BIN_W-1:0]  bin_reg, bin_next;
  logic [BIN_W-1:0]  last_bin_reg, last_bin_next;
  logic [SW-1:0]     scratch_reg, scratch_next;
  logic [SW-1:0]     bcd_reg, bcd_next;

  logic [SW-1:0]       scratch_adj;
  logic [SW+BIN_W-1:0] shifted;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit     (scratch_reg[4*gi +: 4]),
        .digit_adj (scratch_adj[4*gi +: 4])
      );
    end
  endgenerate

  assign shifted = {scratch_adj, bin_reg} << 1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bin_reg      <= '0;
      last_bin_reg <= '0;
      scratch_reg  <= '0;
      bcd_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bin_reg      <= bin_next;
      last_bin_reg <= last_bin_next;
      scratch_reg  <= scratch_next;
      bcd_reg      <= bcd_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bin_next      = bin_reg;
    last_bin_next = last_bin_reg;
    scratch_next  = scratch_reg;
    bcd_next      = bcd_reg;
    case (state_reg)
      IDLE: begin
        if (start || (auto_en && (bin_in != last_bin_reg))) begin
          bin_next      = bin_in;
          last_bin_next = bin_in;
          scratch_next  = '0;
          cnt_next      = '0;
          state_next    = SHIFT;
        end
      end
      SHIFT: begin
        scratch_next = shifted[SW+BIN_W-1:BIN_W];
        bin_next     = shifted[BIN_W-1:0];
        cnt_next     = cnt_reg + 1'b1;
        // Publish only the fully shifted scratch so the display never sees a partial value.
        if (cnt_reg == CNT_LAST) begin
          bcd_next   = shifted[SW+BIN_W-1:BIN_W];
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy    = (state_reg == SHIFT);
  assign done    = (state_reg == DONE);
  assign bcd_out = bcd_reg;

endmodule

// File: tb/tb_ssd_bin2bcd_seq.sv
// Randomized and directed check of ssd_bin2bcd_seq against a decimal-arithmetic model.
module tb_ssd_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic [12:0] bin_in;
  logic        start;
  logic        auto_en;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;

  int total = 0;
  int bad   = 0;

  ssd_bin2bcd_seq dut (
    .clk     (clk),
    .rst     (rst),
    .bin_in  (bin_in),
    .start   (start),
    .auto_en (auto_en),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by repeated division.
  function automatic logic [15:0] bcd_of(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle after the trigger edge; stops in the done cycle.
  task automatic wait_done(output int cyc, output int bc, output bit steady);
    logic [15:0] prev;
    cyc    = 1;
    bc     = 0;
    steady = 1'b1;
    prev   = bcd_out;
    while (!done && cyc < 40) begin
      if (busy) bc++;
      if (bcd_out !== prev) steady = 1'b0;
      tick();
      cyc++;
    end
  endtask

  task automatic conv(input int value, input bit mid_change);
    int  cyc, bc;
    bit  steady;
    bin_in = 13'(value);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    if (mid_change) begin
      tick();
      tick();
      bin_in = 13'd7;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      wait_done(cyc, bc, steady);
      cyc += 3;
      bc  += 3;
    end else begin
      wait_done(cyc, bc, steady);
    end
    check("done_seen", 32'(done), 32'd1);
    check("latency", 32'(cyc), 32'd14);
    check("busy_cycles", 32'(bc), 32'd13);
    check("no_partial", 32'(steady), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("bcd", 32'(bcd_out), 32'(bcd_of(value)));
    $display("conv bin=%0d bcd=0x%04h lat=%0d busy=%0d", value, bcd_out, cyc, bc);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  int cyc, bc, cnt, last_done, v;
  bit steady;

  initial begin
    rst = 1'b0; bin_in = '0; start = 1'b1; auto_en = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    start = 1'b0;
    rst   = 1'b1;
    tick();

    conv(0, 1'b0);
    conv(8191, 1'b0);
    conv(1234, 1'b0);
    conv(1009, 1'b0);
    conv(9, 1'b0);
    conv(10, 1'b0);

    // Operand change and start pulse while shifting must be ignored.
    conv(4095, 1'b1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) cnt++;
      tick();
    end
    check("no_second_conv", 32'(cnt), 32'd0);

    // Reset on the 6th shift edge aborts the conversion.
    bin_in = 13'd4095;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd_out), 32'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) cnt++;
      tick();
    end
    check("abort_no_done", 32'(cnt), 32'd0);

    // Auto mode.
    auto_en = 1'b1;
    bin_in  = 13'd0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) cnt++;
    end
    check("auto_zero_idle", 32'(cnt), 32'd0);
    bin_in = 13'd42;
    tick();
    wait_done(cyc, bc, steady);
    check("auto42_lat", 32'(cyc), 32'd14);
    check("auto42_bcd", 32'(bcd_out), 32'(bcd_of(42)));
    $display("auto bin=42 bcd=0x%04h lat=%0d", bcd_out, cyc);
    tick();
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (done) cnt++;
      tick();
    end
    check("auto_hold", 32'(cnt), 32'd0);
    bin_in = 13'd43;
    tick();
    tick();
    bin_in = 13'd44;
    wait_done(cyc, bc, steady);
    cyc++;
    check("auto43_lat", 32'(cyc), 32'd14);
    check("auto43_bcd", 32'(bcd_out), 32'(bcd_of(43)));
    $display("auto bin=43 bcd=0x%04h lat=%0d", bcd_out, cyc);
    tick();
    wait_done(cyc, bc, steady);
    check("auto44_done", 32'(done), 32'd1);
    check("auto44_bcd", 32'(bcd_out), 32'(bcd_of(44)));
    $display("auto bin=44 bcd=0x%04h", bcd_out);
    tick();
    auto_en = 1'b0;
    tick();

    // Start held high: one result every 15 cycles.
    bin_in = 13'd500;
    start  = 1'b1;
    last_done = -1;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done) begin
        check("held_bcd", 32'(bcd_out), 32'h0500);
        if (last_done >= 0) check("held_period", 32'(i - last_done), 32'd15);
        $display("held done at %0d bcd=0x%04h", i, bcd_out);
        last_done = i;
        cnt++;
      end
    end
    check("held_count", 32'(cnt >= 4), 32'd1);
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    // Random operands.
    for (int n = 0; n < 25; n++) begin
      v = int'($urandom_range(0, 8191));
      conv(v, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ssd_bin2bcd_seq.md
# ssd_bin2bcd_seq

Iterative shift-add-3 (double-dabble) binary-to-BCD converter between the CPU's 13-bit display value and the four-digit seven-segment driver. It accepts a binary value on request, or automatically when the value changes. It produces four packed BCD digits, one nibble per display digit, and holds them stable between conversions so the multiplexed display never shows a partial result. It runs in the CPU clock domain; the driver samples `bcd_out` as a quasi-static bus.

## Interface
- `BIN_W`, default 13: binary input width.
- `DIGITS`, default 4: BCD digits produced. Must satisfy 10^DIGITS > 2^BIN_W − 1; elaboration fails otherwise.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: one clock; reset is synchronous and active-low.
- `bin_in` in BIN_W: unsigned value to convert.
- `start` in 1: conversion request, sampled only in IDLE.
- `auto_en` in 1: when 1, IDLE self-starts whenever `bin_in` ≠ `last_bin`.
- `busy` out 1: high while in SHIFT.
- `done` out 1: one-cycle pulse; `bcd_out` was just updated.
- `bcd_out` out 4·DIGITS: packed BCD; digit 0 (units) in [3:0].

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - Trigger = `start` | (`auto_en` & (`bin_in` ≠ `last_bin`)).
  - On trigger: latch `bin_in` into the shift register and into `last_bin`, clear the BCD scratch, set `cnt` = 0, go to SHIFT.
- **SHIFT**, per edge:
  - For every scratch digit ≥ 5, add 3 (4-bit, no carry out).
  - Then shift {scratch, binary} left by 1.
  - `cnt`++.
  - On the edge where `cnt` == BIN_W−1: write the post-shift scratch to `bcd_out` and go to DONE.
- **DONE**: `done` = 1 for exactly one cycle, then IDLE unconditionally.
- Inputs ignored outside IDLE: `start`, `auto_en`, and `bin_in` changes. The latched operand is used.
- `bcd_out` changes only on the final SHIFT edge and on reset. It is never written with intermediate values.
- `cnt` width is clog2(BIN_W). Scratch width is 4·DIGITS.
- `busy` and `done` are decoded from registered state: glitch-free and never simultaneously high.

## Timing
- Reset (`rst` = 0 at an edge):
  - state = IDLE, `busy` = 0, `done` = 0, `bcd_out` = 0, `last_bin` = 0, `cnt` = 0.
  - Reset overrides any simultaneous `start`.
- Reset mid-conversion aborts the conversion. `bcd_out` reads 0 afterwards, not the old value. No `done` pulse for the aborted operand.
- Trigger sampled at edge k:
  - `busy` is high in cycles k+1 … k+BIN_W.
  - `bcd_out` is valid and `done` = 1 in cycle k+BIN_W+1.
  - Back in IDLE in cycle k+BIN_W+2.
- Latency trigger→`done` = BIN_W+1 edges (14 at default).
- Throughput with `start` held high: one conversion per BIN_W+2 cycles (15).
- Auto mode:
  - After reset, `bin_in` = 0 causes no conversion, because `last_bin` = 0 matches.
  - A `bin_in` change arriving while busy is converted on the first IDLE cycle after DONE.

## Structure
- Shared package `ssd_pkg` holds:
  - the state enum {IDLE, SHIFT, DONE};
  - localparams `SSD_BIN_W` = 13 and `SSD_DIGITS` = 4, reused by the top level and the digit driver.
- Natural sub-module `bcd_digit_adj`: combinational, 4-bit in → 4-bit out, adds 3 when the input is ≥ 5. Instantiate it DIGITS times via generate.
- Everything else is flat: the FSM, the counter, the shift register and the output register.

## Test plan
- Reset, then `start` pulse with `bin_in` = 0 → `done` in cycle 14 after the start edge, `bcd_out` = 0x0000, `busy` high exactly 13 cycles.
- `bin_in` = 8191, `start` → `bcd_out` = 0x8191. `bin_in` = 1234 → 0x1234. `bin_in` = 1009 → 0x1009.
- Start conversion of 4095. Change `bin_in` to 7 and pulse `start` mid-SHIFT → result 0x4095, no second conversion, `busy` uninterrupted.
- Start conversion of 4095. Assert `rst` = 0 at the 6th SHIFT edge → next cycle: `busy` = 0, `done` = 0, `bcd_out` = 0x0000, state IDLE.
- `auto_en` = 1, `start` = 0:
  - `bin_in` 0 → no activity.
  - `bin_in` 0 → 42 → one conversion, `bcd_out` = 0x0042.
  - Hold 42 for 50 cycles → no further `done`.
  - Change to 43 → `bcd_out` = 0x0043.
- `start` held high continuously with `bin_in` = 500 → `done` pulses every 15 cycles, `bcd_out` steady at 0x0500.
